xm_inst_encoder: RTL and testbench

Sequential instruction encoder for the X-Makina ISA. It accepts structured instruction commands and emits 16-bit instruction words over a valid/ready stream. The debug/boot injection path and the test-program loader use it to feed the fetch stage, or to write program memory, without hand-packed opcodes. It expands the LDI16 pseudo-op into one or two immediate-load words, and it range-checks offsets.

---
 rtl/xm_inst_encoder_if.sv | 43 ++++
 rtl/xm_inst_encoder.sv | 158 +++++++++++++++
 tb/tb_xm_inst_encoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/xm_inst_encoder_if.sv
// rtl/xm_inst_encoder_if.sv - command/instruction stream bundle for xm_inst_encoder
//
// Purpose : groups the command channel, the instruction-word stream and the
//           error status of the X-Makina instruction encoder.
// Modports:
//   slave  - the encoder: consumes cmd_*, inst_ready_i; drives cmd_ready_o,
//            inst_valid_o, inst_o, inst_last_o, err_o, errCode_o
//   master - the command source / stream sink (mirror of slave)
interface xm_inst_encoder_if #(
  parameter int WORD = 16
);
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [2:0]      cmd_op_i;
  logic [3:0]      cmd_alu_i;
  logic            cmd_const_i;
  logic            cmd_byte_i;
  logic [2:0]      cmd_src_i;
  logic [2:0]      cmd_dst_i;
  logic [2:0]      cmd_cond_i;
  logic [WORD-1:0] cmd_offset_i;
  logic [WORD-1:0] cmd_imm_i;
  logic            inst_valid_o;
  logic [WORD-1:0] inst_o;
  logic            inst_last_o;
  logic            inst_ready_i;
  logic            err_o;
  logic [1:0]      errCode_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_alu_i, cmd_const_i, cmd_byte_i,
           cmd_src_i, cmd_dst_i, cmd_cond_i, cmd_offset_i, cmd_imm_i,
           inst_ready_i,
    output cmd_ready_o, inst_valid_o, inst_o, inst_last_o, err_o, errCode_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_alu_i, cmd_const_i, cmd_byte_i,
           cmd_src_i, cmd_dst_i, cmd_cond_i, cmd_offset_i, cmd_imm_i,
           inst_ready_i,
    input  cmd_ready_o, inst_valid_o, inst_o, inst_last_o, err_o, errCode_o
  );
endinterface

// File: rtl/xm_inst_encoder.sv
// rtl/xm_inst_encoder.sv - X-Makina structured-command to 16-bit instruction encoder
//
// Purpose : turns instruction commands into instruction words on a valid/ready
//           stream, expanding LDI16 into one or two immediate loads and
//           rejecting out-of-range offsets and illegal ops.
// Ports   :
//   clk_i   - clock, rising edge
//   arst_i  - asynchronous reset, active-low
//   bus     - xm_inst_encoder_if.slave (command in, instruction stream out,
//             err_o pulse and errCode_o status)
module xm_inst_encoder #(
  parameter int WORD = 16
) (
  input  logic                clk_i,
  input  logic                arst_i,
  xm_inst_encoder_if.slave    bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [1:0] IMM_MOVLZ = 2'b01;
  localparam logic [1:0] IMM_MOVLS = 2'b10;
  localparam logic [1:0] IMM_MOVH  = 2'b11;

  logic [1:0]      state_q, state_d;
  logic [WORD-1:0] inst_q, inst_d;
  logic [WORD-1:0] hold_q, hold_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;

  logic [WORD-1:0] word0, word1;
  logic            two_words;
  logic            legal;
  logic [1:0]      code;
  logic            accept;
  logic            ok_cb, ok_bl, ok_ls;

  logic [WORD-1:0] off;
  logic [WORD-1:0] imm;
  assign off = bus.cmd_offset_i;
  assign imm = bus.cmd_imm_i;

  // An offset fits when every bit above the field MSB is a copy of that MSB.
  assign ok_cb = (&off[15:9])  | ~(|off[15:9]);
  assign ok_bl = (&off[15:12]) | ~(|off[15:12]);
  assign ok_ls = (&off[15:6])  | ~(|off[15:6]);

  // A new command fits only if the output register is empty or is being
  // drained this very cycle; TWO always has a MOVH still to emit.
  assign bus.cmd_ready_o = (state_q == ST_EMPTY) ||
                           ((state_q == ST_ONE) && bus.inst_ready_i);
  assign accept = bus.cmd_valid_i && bus.cmd_ready_o;

  always_comb begin
    word0     = '0;
    word1     = '0;
    two_words = 1'b0;
    legal     = 1'b1;
    code      = 2'd0;
    case (bus.cmd_op_i)
      3'd0: word0 = {4'b0100, bus.cmd_alu_i, bus.cmd_const_i, bus.cmd_byte_i,
                     bus.cmd_src_i, bus.cmd_dst_i};
      3'd1: begin
        word0 = {3'b001, bus.cmd_cond_i, off[9:0]};
        legal = ok_cb;
      end
      3'd2: begin
        word0 = {3'b000, off[12:0]};
        legal = ok_bl;
      end
      3'd3: begin
        word0 = {2'b10, off[6:0], bus.cmd_byte_i, bus.cmd_src_i, bus.cmd_dst_i};
        legal = ok_ls;
      end
      3'd4: begin
        word0 = {2'b11, off[6:0], bus.cmd_byte_i, bus.cmd_src_i, bus.cmd_dst_i};
        legal = ok_ls;
      end
      3'd5: begin
        // A high byte that is pure zero- or sign-extension needs only one word.
        if (imm[15:8] == 8'h00) begin
          word0 = {3'b011, IMM_MOVLZ, imm[7:0], bus.cmd_dst_i};
        end else if (imm[15:8] == 8'hFF) begin
          word0 = {3'b011, IMM_MOVLS, imm[7:0], bus.cmd_dst_i};
        end else begin
          word0     = {3'b011, IMM_MOVLZ, imm[7:0], bus.cmd_dst_i};
          word1     = {3'b011, IMM_MOVH, imm[15:8], bus.cmd_dst_i};
          two_words = 1'b1;
        end
      end
      default: begin
        legal = 1'b0;
        code  = 2'd2;
      end
    endcase
    if (!legal && (code == 2'd0)) begin
      code = 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    hold_d  = hold_q;
    last_d  = last_q;
    err_d   = 1'b0;
    code_d  = code_q;
    if (accept) begin
      code_d = code;
      if (!legal) begin
        // Rejected: anything held in ONE drained on this same edge.
        err_d   = 1'b1;
        state_d = ST_EMPTY;
      end else begin
        inst_d  = word0;
        hold_d  = word1;
        last_d  = !two_words;
        state_d = two_words ? ST_TWO : ST_ONE;
      end
    end else if (bus.inst_ready_i) begin
      if (state_q == ST_ONE) begin
        state_d = ST_EMPTY;
      end else if (state_q == ST_TWO) begin
        inst_d  = hold_q;
        last_d  = 1'b1;
        state_d = ST_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= ST_EMPTY;
      inst_q  <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign bus.inst_valid_o = (state_q != ST_EMPTY);
  assign bus.inst_o       = inst_q;
  assign bus.inst_last_o  = last_q;
  assign bus.err_o        = err_q;
  assign bus.errCode_o    = code_q;

endmodule

// File: tb/tb_xm_inst_encoder.sv
// tb/tb_xm_inst_encoder.sv - directed-vector bench for xm_inst_encoder
module tb_xm_inst_encoder;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  xm_inst_encoder_if #(.WORD(16)) bus ();

  xm_inst_encoder #(.WORD(16)) dut (
    .clk_i  (clk),
    .arst_i (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns on the falling edge after the
  // accepting rising edge with cmd_valid_i dropped.
  task automatic send(input logic [2:0] op, input logic [3:0] alu, input logic cst,
                      input logic byt, input logic [2:0] src, input logic [2:0] dst,
                      input logic [2:0] cond, input logic [15:0] off, input logic [15:0] imm);
    int n;
    bus.cmd_op_i     = op;
    bus.cmd_alu_i    = alu;
    bus.cmd_const_i  = cst;
    bus.cmd_byte_i   = byt;
    bus.cmd_src_i    = src;
    bus.cmd_dst_i    = dst;
    bus.cmd_cond_i   = cond;
    bus.cmd_offset_i = off;
    bus.cmd_imm_i    = imm;
    bus.cmd_valid_i  = 1'b1;
    #1;
    n = 0;
    while (!bus.cmd_ready_o && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check_eq("cmd_ready_wait", 32'(bus.cmd_ready_o), 32'd1);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] w, input logic last);
    check_eq({tag, "_valid"}, 32'(bus.inst_valid_o), 32'd1);
    check_eq({tag, "_inst"},  32'(bus.inst_o), 32'(w));
    check_eq({tag, "_last"},  32'(bus.inst_last_o), 32'(last));
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check_eq({tag, "_drained"}, 32'(bus.inst_valid_o), 32'd0);
  endtask

  task automatic expect_reject(input string tag, input logic [1:0] code);
    check_eq({tag, "_err"},   32'(bus.err_o), 32'd1);
    check_eq({tag, "_code"},  32'(bus.errCode_o), 32'(code));
    check_eq({tag, "_noword"}, 32'(bus.inst_valid_o), 32'd0);
    @(negedge clk);
    check_eq({tag, "_errpulse"}, 32'(bus.err_o), 32'd0);
    check_eq({tag, "_codehold"}, 32'(bus.errCode_o), 32'(code));
  endtask

  logic [15:0] b2b_exp [3];

  initial begin
    tests = 0;
    fails = 0;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_op_i     = '0;
    bus.cmd_alu_i    = '0;
    bus.cmd_const_i  = 1'b0;
    bus.cmd_byte_i   = 1'b0;
    bus.cmd_src_i    = '0;
    bus.cmd_dst_i    = '0;
    bus.cmd_cond_i   = '0;
    bus.cmd_offset_i = '0;
    bus.cmd_imm_i    = '0;
    bus.inst_ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(bus.inst_valid_o), 32'd0);
    check_eq("rst_inst",  32'(bus.inst_o), 32'd0);
    check_eq("rst_last",  32'(bus.inst_last_o), 32'd0);
    check_eq("rst_err",   32'(bus.err_o), 32'd0);
    check_eq("rst_code",  32'(bus.errCode_o), 32'd0);
    check_eq("rst_ready", 32'(bus.cmd_ready_o), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU, alu=0 const=0 byte=0 src=2 dst=1
    send(3'd0, 4'h0, 1'b0, 1'b0, 3'd2, 3'd1, 3'd0, 16'h0000, 16'h0000);
    expect_word("alu", 16'h4011, 1'b1);
    check_eq("alu_code", 32'(bus.errCode_o), 32'd0);
    expect_idle("alu");

    // LDI16 0x1234 dst=3 with the sink stalled for two cycles
    bus.inst_ready_i = 1'b0;
    send(3'd5, 4'h0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd0, 16'h0000, 16'h1234);
    expect_word("ldi_lo", 16'h69A3, 1'b0);
    check_eq("ldi_two_notready", 32'(bus.cmd_ready_o), 32'd0);
    @(negedge clk);
    expect_word("ldi_lo_hold", 16'h69A3, 1'b0);
    bus.inst_ready_i = 1'b1;
    #1;
    check_eq("ldi_two_notready2", 32'(bus.cmd_ready_o), 32'd0);
    @(negedge clk);
    expect_word("ldi_hi", 16'h7893, 1'b1);
    check_eq("ldi_one_ready", 32'(bus.cmd_ready_o), 32'd1);
    expect_idle("ldi_hi");

    // LDI16 0xFF80 dst=0 -> single MOVLS
    send(3'd5, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'hFF80);
    expect_word("ldi_ls", 16'h7400, 1'b1);
    expect_idle("ldi_ls");

    // CB cond=NE offset=-1
    send(3'd1, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 16'hFFFF, 16'h0000);
    expect_word("cb", 16'h27FF, 1'b1);
    expect_idle("cb");

    // CB offset=512 -> range error
    send(3'd1, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 16'd512, 16'h0000);
    expect_reject("cb_range", 2'd1);

    // LDR offset=-64 byte=1 src=4 dst=5, clears errCode
    send(3'd3, 4'h0, 1'b0, 1'b1, 3'd4, 3'd5, 3'd0, 16'hFFC0, 16'h0000);
    expect_word("ldr", 16'hA065, 1'b1);
    check_eq("ldr_code", 32'(bus.errCode_o), 32'd0);
    expect_idle("ldr");

    // STR offset=64 -> range error
    send(3'd4, 4'h0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 16'd64, 16'h0000);
    expect_reject("str_range", 2'd1);

    // op=6 -> illegal
    send(3'd6, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000);
    expect_reject("illegal", 2'd2);

    // BL offset=4095
    send(3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'd4095, 16'h0000);
    expect_word("bl", 16'h0FFF, 1'b1);
    check_eq("bl_code", 32'(bus.errCode_o), 32'd0);
    expect_idle("bl");

    // Three back-to-back ALU commands: alu=i+1, dst=i
    b2b_exp[0] = 16'h4100;
    b2b_exp[1] = 16'h4201;
    b2b_exp[2] = 16'h4302;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_op_i    = 3'd0;
      bus.cmd_alu_i   = 4'(i + 1);
      bus.cmd_const_i = 1'b0;
      bus.cmd_byte_i  = 1'b0;
      bus.cmd_src_i   = 3'd0;
      bus.cmd_dst_i   = 3'(i);
      bus.cmd_valid_i = 1'b1;
      #1;
      check_eq($sformatf("b2b_ready%0d", i), 32'(bus.cmd_ready_o), 32'd1);
      @(negedge clk);
      expect_word($sformatf("b2b%0d", i), b2b_exp[i], 1'b1);
    end
    bus.cmd_valid_i = 1'b0;
    expect_idle("b2b");

    // Asynchronous reset while the MOVH of LDI16 0x1234 is pending
    bus.inst_ready_i = 1'b0;
    send(3'd5, 4'h0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd0, 16'h0000, 16'h1234);
    expect_word("arst_pre", 16'h69A3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.inst_valid_o), 32'd0);
    check_eq("arst_inst",  32'(bus.inst_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.inst_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("arst_nomovh%0d", i), 32'(bus.inst_valid_o), 32'd0);
    end
    check_eq("arst_empty_ready", 32'(bus.cmd_ready_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
